// File: rtl/kp_pkg.sv
// Shared field widths, FIFO entry layout and FSM encoding for the keypoint buffer.
// Entry = {eof, payload}; keypoint payload {x,y,score,cos,sin}, marker payload {kp_count, drop_count, pad}.
package kp_pkg;

  localparam int X_W     = 10;
  localparam int Y_W     = 10;
  localparam int SCORE_W = 8;
  localparam int TRIG_W  = 12;

  localparam int PAY_W   = X_W + Y_W + SCORE_W + 2 * TRIG_W;
  localparam int ENTRY_W = PAY_W + 1;
  localparam int EOF_BIT = PAY_W;

  localparam int SIN_LSB   = 0;
  localparam int COS_LSB   = SIN_LSB + TRIG_W;
  localparam int SCORE_LSB = COS_LSB + TRIG_W;
  localparam int Y_LSB     = SCORE_LSB + SCORE_W;
  localparam int X_LSB     = Y_LSB + Y_W;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  function automatic logic [ENTRY_W-1:0] pack_kp(
    input logic [X_W-1:0]     x,
    input logic [Y_W-1:0]     y,
    input logic [SCORE_W-1:0] score,
    input logic [TRIG_W-1:0]  cos_v,
    input logic [TRIG_W-1:0]  sin_v
  );
    return {1'b0, x, y, score, cos_v, sin_v};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered show-ahead head: head_dat holds the oldest entry
// one cycle after it is written; pops on an empty FIFO and pushes into a full one are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [AW:0]      used,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_nxt;
  logic [AW:0]      used_q;
  logic [WIDTH-1:0] head_q;
  logic             do_push;
  logic             do_pop;

  assign empty    = (used_q == '0);
  assign full     = (used_q == (AW+1)'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign rd_nxt   = rd_ptr + AW'(do_pop);
  assign used     = used_q;
  assign head_dat = head_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // The head register looks one pop ahead; a write landing on the next head slot is forwarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used_q <= '0;
      head_q <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_nxt;
      used_q <= used_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      head_q <= (do_push && (wr_ptr == rd_nxt)) ? push_dat : mem[rd_nxt];
    end
  end

endmodule

// File: rtl/keypoint_buffer.sv
// Buffers FAST keypoints per frame and re-streams them over valid/ready, closing each frame
// with a marker beat carrying kept/dropped counts; one FIFO slot is always kept for the marker.
module keypoint_buffer
  import kp_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int CNT_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_end,
  input  logic               i_flag,
  input  logic [X_W-1:0]     i_x,
  input  logic [Y_W-1:0]     i_y,
  input  logic [SCORE_W-1:0] i_score,
  input  logic [TRIG_W-1:0]  i_cos,
  input  logic [TRIG_W-1:0]  i_sin,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_eof,
  output logic [X_W-1:0]     o_x,
  output logic [Y_W-1:0]     o_y,
  output logic [SCORE_W-1:0] o_score,
  output logic [TRIG_W-1:0]  o_cos,
  output logic [TRIG_W-1:0]  o_sin,
  output logic [CNT_W-1:0]   o_kp_count,
  output logic [CNT_W-1:0]   o_drop_count,
  output logic               o_overflow
);

  localparam int MK_W  = 2 * CNT_W;
  localparam int PAD_W = PAY_W - MK_W;
  localparam logic [AW:0] KP_LIMIT = (AW+1)'(DEPTH - 1);

  state_t             state;
  logic [CNT_W-1:0]   kp_cnt;
  logic [CNT_W-1:0]   drop_cnt;
  logic [CNT_W-1:0]   kp_nxt;
  logic [CNT_W-1:0]   drop_nxt;
  logic [MK_W-1:0]    mq0;
  logic [MK_W-1:0]    mq1;
  logic [MK_W-1:0]    mk_new;
  logic [1:0]         mq_cnt;
  logic               overflow_q;

  logic               active;
  logic               kp_push;
  logic               kp_drop;
  logic               end_evt;
  logic               mk_push;
  logic [ENTRY_W-1:0] push_dat;
  logic [ENTRY_W-1:0] head;
  logic [AW:0]        used;
  logic               full;
  logic               empty;
  logic               is_kp;
  logic               is_eof;

  always_comb begin
    active   = (state == ST_ACTIVE);
    kp_push  = active && i_flag && (used < KP_LIMIT);
    kp_drop  = active && i_flag && !kp_push;
    // A keypoint arriving with the end pulse belongs to the ending frame.
    kp_nxt   = (kp_push && (kp_cnt != '1)) ? kp_cnt + 1'b1 : kp_cnt;
    drop_nxt = (kp_drop && (drop_cnt != '1)) ? drop_cnt + 1'b1 : drop_cnt;
    mk_new   = {kp_nxt, drop_nxt};
    end_evt  = active && (i_end || i_start);
    mk_push  = (mq_cnt != 2'd0) && !full && !kp_push;
    push_dat = kp_push ? pack_kp(i_x, i_y, i_score, i_cos, i_sin)
                       : {1'b1, mq0, {PAD_W{1'b0}}};
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk      (i_clk),
    .rst      (i_rst),
    .push     (kp_push || mk_push),
    .push_dat (push_dat),
    .pop      (i_ready),
    .head_dat (head),
    .used     (used),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      kp_cnt     <= '0;
      drop_cnt   <= '0;
      mq0        <= '0;
      mq1        <= '0;
      mq_cnt     <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      if (kp_drop) begin
        overflow_q <= 1'b1;
      end

      if (i_start) begin
        state    <= ST_ACTIVE;
        kp_cnt   <= '0;
        drop_cnt <= '0;
      end else begin
        if (active && i_end) begin
          state <= ST_IDLE;
        end
        kp_cnt   <= kp_nxt;
        drop_cnt <= drop_nxt;
      end

      // Two-deep marker queue: mq0 is the next marker to enter the FIFO.
      case ({mk_push, end_evt})
        2'b10: begin
          mq0    <= mq1;
          mq_cnt <= mq_cnt - 2'd1;
        end
        2'b01: begin
          if (mq_cnt == 2'd0) begin
            mq0    <= mk_new;
            mq_cnt <= 2'd1;
          end else if (mq_cnt == 2'd1) begin
            mq1    <= mk_new;
            mq_cnt <= 2'd2;
          end
        end
        2'b11: begin
          if (mq_cnt == 2'd1) begin
            mq0 <= mk_new;
          end else begin
            mq0 <= mq1;
            mq1 <= mk_new;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    is_kp        = !empty && !head[EOF_BIT];
    is_eof       = !empty && head[EOF_BIT];
    o_valid      = !empty;
    o_eof        = is_eof;
    o_x          = is_kp ? head[X_LSB +: X_W] : '0;
    o_y          = is_kp ? head[Y_LSB +: Y_W] : '0;
    o_score      = is_kp ? head[SCORE_LSB +: SCORE_W] : '0;
    o_cos        = is_kp ? head[COS_LSB +: TRIG_W] : '0;
    o_sin        = is_kp ? head[SIN_LSB +: TRIG_W] : '0;
    o_kp_count   = is_eof ? head[PAY_W-1 -: CNT_W] : '0;
    o_drop_count = is_eof ? head[PAY_W-1-CNT_W -: CNT_W] : '0;
    o_overflow   = overflow_q;
  end

endmodule

// File: tb/tb_keypoint_buffer.sv
// Bench for keypoint_buffer: a frame-level queue model checked every cycle, plus directed
// frames whose popped beats are compared against hand-computed values.
module tb_keypoint_buffer;

  localparam int DEPTH = 64;

  typedef struct packed {
    logic        eof;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [7:0]  sc;
    logic [11:0] c;
    logic [11:0] s;
    logic [15:0] kc;
    logic [15:0] dc;
  } beat_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0, i_end = 1'b0, i_flag = 1'b0, i_ready = 1'b0;
  logic [9:0]  i_x = '0, i_y = '0;
  logic [7:0]  i_score = '0;
  logic [11:0] i_cos = '0, i_sin = '0;
  logic        o_valid, o_eof, o_overflow;
  logic [9:0]  o_x, o_y;
  logic [7:0]  o_score;
  logic [11:0] o_cos, o_sin;
  logic [15:0] o_kp_count, o_drop_count;

  keypoint_buffer #(.DEPTH(DEPTH), .AW(6), .CNT_W(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_end(i_end), .i_flag(i_flag),
    .i_x(i_x), .i_y(i_y), .i_score(i_score), .i_cos(i_cos), .i_sin(i_sin),
    .o_valid(o_valid), .i_ready(i_ready), .o_eof(o_eof), .o_x(o_x), .o_y(o_y),
    .o_score(o_score), .o_cos(o_cos), .o_sin(o_sin), .o_kp_count(o_kp_count),
    .o_drop_count(o_drop_count), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  beat_t dut_beat;
  assign dut_beat = {o_eof, o_x, o_y, o_score, o_cos, o_sin, o_kp_count, o_drop_count};

  // Model: queue of buffered beats, list of markers waiting for a slot, frame counters.
  beat_t       mq[$];
  beat_t       mpend[$];
  beat_t       blog[$];
  beat_t       tmp, tmp2;
  bit          m_act = 0, m_ovf = 0, m_live = 0, m_kpush;
  int          m_used;
  logic [15:0] m_kp = '0, m_dp = '0;

  always @(posedge i_clk) begin
    if (i_rst) begin
      mq.delete();
      mpend.delete();
      m_act = 0; m_ovf = 0; m_kp = '0; m_dp = '0; m_live = 1;
    end else if (m_live) begin
      m_used  = mq.size();
      m_kpush = m_act && i_flag && (m_used < DEPTH - 1);
      if (m_used != 0 && i_ready) tmp2 = mq.pop_front();
      if (m_act && i_flag) begin
        if (m_kpush) begin
          if (m_kp != 16'hFFFF) m_kp = m_kp + 16'd1;
          tmp = '0;
          tmp.x = i_x; tmp.y = i_y; tmp.sc = i_score; tmp.c = i_cos; tmp.s = i_sin;
          mq.push_back(tmp);
        end else begin
          if (m_dp != 16'hFFFF) m_dp = m_dp + 16'd1;
          m_ovf = 1;
        end
      end
      if (!m_kpush && mpend.size() != 0 && m_used < DEPTH) mq.push_back(mpend.pop_front());
      if (m_act && (i_end || i_start) && mpend.size() < 2) begin
        tmp = '0;
        tmp.eof = 1'b1; tmp.kc = m_kp; tmp.dc = m_dp;
        mpend.push_back(tmp);
      end
      if (i_start) begin
        m_act = 1; m_kp = '0; m_dp = '0;
      end else if (i_end) begin
        m_act = 0;
      end
    end
  end

  always @(negedge i_clk) begin
    if (m_live) begin
      chk("status", {o_valid, o_overflow}, {mq.size() != 0, m_ovf});
      if (o_valid && mq.size() != 0) chk("beat", dut_beat, mq[0]);
      if (o_valid && i_ready) blog.push_back(dut_beat);
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
    i_start = 1'b0; i_end = 1'b0; i_flag = 1'b0;
  endtask

  task automatic kp(input int x, input int y);
    i_flag = 1'b1; i_x = 10'(x); i_y = 10'(y);
    i_score = 8'(x + y); i_cos = 12'(x); i_sin = 12'(-y);
    tick();
  endtask

  task automatic frame_start();
    i_start = 1'b1;
    tick();
  endtask

  task automatic drain(input int max);
    int n = 0;
    i_ready = 1'b1;
    while ((o_valid || mq.size() != 0 || mpend.size() != 0) && n < max) begin
      tick();
      n++;
    end
    chk("drain_done", n < max, 1);
  endtask

  task automatic chk_kp(input string nm, input int idx, input int x, input int y);
    if (idx >= blog.size()) chk({nm, "_missing"}, 0, 1);
    else chk(nm, {blog[idx].eof, blog[idx].x, blog[idx].y}, {1'b0, 10'(x), 10'(y)});
  endtask

  task automatic chk_mk(input string nm, input int idx, input int kc, input int dc);
    if (idx >= blog.size()) chk({nm, "_missing"}, 0, 1);
    else chk(nm, {blog[idx].eof, blog[idx].x, blog[idx].kc, blog[idx].dc},
             {1'b1, 10'd0, 16'(kc), 16'(dc)});
  endtask

  int sent_x[$];
  int errs, cyc;

  initial begin
    repeat (3) tick();
    i_rst = 1'b0;
    chk("rst_valid", o_valid, 0);
    chk("rst_overflow", o_overflow, 0);
    chk("rst_counts", {o_eof, o_kp_count, o_drop_count}, 0);

    // Three keypoints then end; consumer always ready.
    blog.delete();
    i_ready = 1'b1;
    frame_start();
    kp(5, 7); kp(8, 9); kp(100, 40);
    i_end = 1'b1; tick();
    drain(50);
    chk("t1_len", blog.size(), 4);
    chk_kp("t1_kp0", 0, 5, 7);
    chk_kp("t1_kp1", 1, 8, 9);
    chk_kp("t1_kp2", 2, 100, 40);
    chk_mk("t1_mk", 3, 3, 0);

    // Flags while idle are ignored; an empty frame still yields a zero marker.
    blog.delete();
    kp(1, 1); kp(2, 2); kp(3, 3); tick();
    chk("idle_valid", o_valid, 0);
    chk("idle_len", blog.size(), 0);
    frame_start();
    i_end = 1'b1; tick();
    drain(50);
    chk("idle_frame_len", blog.size(), 1);
    chk_mk("idle_mk", 0, 0, 0);

    // Flag coincident with end counts in the ending frame.
    blog.delete();
    frame_start();
    kp(20, 21);
    i_end = 1'b1; kp(22, 23);
    drain(50);
    chk("t3_len", blog.size(), 3);
    chk_kp("t3_kp1", 1, 22, 23);
    chk_mk("t3_mk", 2, 2, 0);

    // Overflow: 70 keypoints into a stalled 64-deep buffer.
    blog.delete();
    i_ready = 1'b0;
    frame_start();
    for (int i = 0; i < 70; i++) kp(i, 69 - i);
    i_end = 1'b1; tick();
    repeat (3) tick();
    chk("ovf_head", {o_valid, o_eof, o_x, o_y}, {1'b1, 1'b0, 10'd0, 10'd69});
    chk("ovf_flag", o_overflow, 1);
    drain(200);
    chk("ovf_len", blog.size(), 64);
    for (int i = 0; i < 63; i++) chk_kp("ovf_kp", i, i, 69 - i);
    chk_mk("ovf_mk", 63, 63, 7);

    // Restart without end: implicit end of the first frame.
    blog.delete();
    i_ready = 1'b1;
    frame_start();
    kp(1, 2); kp(3, 4);
    frame_start();
    tick();
    kp(5, 6);
    i_end = 1'b1; tick();
    drain(50);
    chk("t6_len", blog.size(), 5);
    chk_mk("t6_mk0", 2, 2, 0);
    chk_kp("t6_kp", 3, 5, 6);
    chk_mk("t6_mk1", 4, 1, 0);

    // 500 keypoints with a randomly stalling consumer.
    blog.delete();
    sent_x.delete();
    frame_start();
    cyc = 0;
    while (sent_x.size() < 500 && cyc < 10000) begin
      i_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        sent_x.push_back(sent_x.size());
        kp(sent_x.size() - 1, ((sent_x.size() - 1) * 7) % 1024);
      end else begin
        tick();
      end
      cyc++;
    end
    i_end = 1'b1; tick();
    drain(300);
    chk("rand_len", blog.size(), 501);
    errs = 0;
    for (int i = 0; i < 500 && i < blog.size(); i++)
      if ({blog[i].eof, blog[i].x, blog[i].y} !== {1'b0, 10'(i), 10'((i * 7) % 1024)}) errs++;
    chk("rand_order", errs, 0);
    chk_mk("rand_mk", 500, 500, 0);

    // Reset mid-frame flushes everything without a marker.
    i_ready = 1'b0;
    frame_start();
    kp(1, 1); kp(2, 2); kp(3, 3);
    chk("pre_rst_valid", o_valid, 1);
    i_rst = 1'b1; tick();
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_overflow", o_overflow, 0);
    i_rst = 1'b0;
    repeat (3) tick();
    chk("post_rst_valid", o_valid, 0);
    blog.delete();
    i_ready = 1'b1;
    frame_start();
    kp(9, 9);
    i_end = 1'b1; tick();
    drain(50);
    chk("post_rst_len", blog.size(), 2);
    chk_kp("post_rst_kp", 0, 9, 9);
    chk_mk("post_rst_mk", 1, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
